catraca_tarifada: RTL and testbench
===================================

CATRACA_TARIFADA -- requirements
Module: catraca_tarifada

Interface
REQ-001 Parameter FARE, default 2: coins required per passage; legal range 1..MAX_CREDIT.
REQ-002 Parameter MAX_CREDIT, default 15: credit saturation limit, >= 1.
REQ-003 Parameter TIMEOUT, default 50: maximum cycles in UNLOCKED without a push, >= 1.
REQ-004 Parameter CNT_W, default 8: passage counter width, >= 1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 coin_i  input  1  one coin per cycle sampled high.
REQ-008 push_i  input  1  passage attempt, sampled each cycle.
REQ-009 alarm_ack_i  input  1  operator clears alarm.
REQ-010 locked_o  output  1  high in LOCKED and ALARM.
REQ-011 unlocked_o  output  1  high in UNLOCKED only.
REQ-012 alarm_o  output  1  high in ALARM only.
REQ-013 credit_o  output  $clog2(MAX_CREDIT+1)  current credit.
REQ-014 counter_o  output  CNT_W  completed passages.
REQ-015 coin_reject_o  output  1  one-cycle registered pulse, coin refused at saturation.

Function
REQ-016 States LOCKED, UNLOCKED, ALARM; locked_o, unlocked_o and alarm_o are Moore outputs decoded from the state register.
REQ-017 Every state: coin_i high -> credit += 1 if credit < MAX_CREDIT, else credit unchanged and coin_reject_o = 1 the next cycle.
REQ-018 LOCKED, push_i = 1 -> ALARM next cycle; push has priority over unlock; a coin in the same cycle is still credited per REQ-017.
REQ-019 LOCKED, push_i = 0, new_credit (credit after REQ-017) >= FARE -> UNLOCKED next cycle, credit <= new_credit - FARE, timer <= 0.
REQ-020 Prepaid credit >= FARE with no coin also unlocks per REQ-019, one cycle after entering LOCKED.
REQ-021 UNLOCKED, push_i = 1 -> LOCKED next cycle, counter += 1 modulo 2^CNT_W (wraps, no saturation).
REQ-022 UNLOCKED, push_i = 0: timer += 1; when timer == TIMEOUT-1 -> LOCKED next cycle, fare forfeited, counter unchanged; UNLOCKED therefore lasts at most TIMEOUT cycles.
REQ-023 Push and timeout in the same cycle -> push wins (passage counted).
REQ-024 ALARM, alarm_ack_i = 1 and push_i = 0 -> LOCKED next cycle; ack with push held -> remain in ALARM.
REQ-025 Credit arithmetic is unsigned; credit never exceeds MAX_CREDIT and never underflows.

Reset
REQ-026 rst = 1 at a rising edge -> state LOCKED, credit 0, counter 0, timer 0, coin_reject_o 0, regardless of current state; all other inputs ignored in that cycle.
REQ-027 Reset mid-UNLOCKED or mid-ALARM discards credit and the pending passage; outputs read locked_o = 1, unlocked_o = 0, alarm_o = 0 from the first cycle after the reset edge.

Structure
REQ-028 Package catraca_pkg holds the state enum typedef (catraca_state_t) and the default parameter constants.
REQ-029 The timeout counter is a sub-module catraca_timer (clear, enable, expired output, TIMEOUT parameter); the FSM, credit and counter logic stay in catraca_tarifada.

Verification (FARE=2, MAX_CREDIT=3, TIMEOUT=4, CNT_W=3)
REQ-030 Reset, then push_i = 1 for 1 cycle -> alarm_o = 1, locked_o = 1; then alarm_ack_i = 1 -> locked_o = 1, alarm_o = 0 next cycle.
REQ-031 Two coin pulses -> unlocked_o = 1 the cycle after the second coin, credit_o = 0; then push_i = 1 -> locked_o = 1, counter_o = 1.
REQ-032 Unlock via two coins, then no push -> unlocked_o high exactly 4 cycles, then locked_o = 1, credit_o = 0, counter_o = 0.
REQ-033 Unlock, then 4 coins while UNLOCKED -> credit_o = 3 and coin_reject_o pulses once; push -> LOCKED for 1 cycle, then auto-UNLOCKED, credit_o = 1.
REQ-034 8 paid passages -> counter_o wraps to 0; a push coincident with the timeout cycle -> counter increments.
REQ-035 Reset asserted while UNLOCKED with credit_o = 1 -> locked_o = 1, credit_o = 0, counter_o = 0.

Source files
------------

// File: rtl/catraca_pkg.sv
// Shared types and default constants for the fare-collecting turnstile.
package catraca_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED,
        ST_UNLOCKED,
        ST_ALARM
    } catraca_state_t;

    localparam int FARE_DEF       = 2;
    localparam int MAX_CREDIT_DEF = 15;
    localparam int TIMEOUT_DEF    = 50;
    localparam int CNT_W_DEF      = 8;

endpackage

// File: rtl/catraca_timer.sv
// Idle-time counter for the unlocked window; expired marks the last allowed cycle.
module catraca_timer
    import catraca_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] count;

    assign expired = (count == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/catraca_tarifada.sv
// Coin-operated turnstile: credit accounting, passage counter and lock FSM.
module catraca_tarifada
    import catraca_pkg::*;
#(
    parameter int FARE       = FARE_DEF,
    parameter int MAX_CREDIT = MAX_CREDIT_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            coin_i,
    input  logic                            push_i,
    input  logic                            alarm_ack_i,
    output logic                            locked_o,
    output logic                            unlocked_o,
    output logic                            alarm_o,
    output logic [$clog2(MAX_CREDIT+1)-1:0] credit_o,
    output logic [CNT_W-1:0]                counter_o,
    output logic                            coin_reject_o
);

    localparam int CW = $clog2(MAX_CREDIT + 1);

    catraca_state_t state, state_n;
    logic [CW-1:0]  credit, credit_n, credit_inc;
    logic [CNT_W-1:0] counter, counter_n;
    logic           reject, reject_n;
    logic           saturated;
    logic           t_expired;

    catraca_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .clear   (rst || (state != ST_UNLOCKED)),
        .enable  ((state == ST_UNLOCKED) && !push_i),
        .expired (t_expired)
    );

    assign saturated  = (credit == CW'(MAX_CREDIT));
    assign credit_inc = (coin_i && !saturated) ? credit + CW'(1) : credit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_LOCKED;
            credit  <= '0;
            counter <= '0;
            reject  <= 1'b0;
        end else begin
            state   <= state_n;
            credit  <= credit_n;
            counter <= counter_n;
            reject  <= reject_n;
        end
    end

    always_comb begin
        state_n   = state;
        credit_n  = credit_inc;
        counter_n = counter;
        reject_n  = coin_i && saturated;
        unique case (state)
            ST_LOCKED: begin
                // push outranks unlock; the coin is still credited
                if (push_i) begin
                    state_n = ST_ALARM;
                end else if (credit_inc >= CW'(FARE)) begin
                    state_n  = ST_UNLOCKED;
                    credit_n = credit_inc - CW'(FARE);
                end
            end
            ST_UNLOCKED: begin
                if (push_i) begin
                    state_n   = ST_LOCKED;
                    counter_n = counter + CNT_W'(1);
                end else if (t_expired) begin
                    state_n = ST_LOCKED;
                end
            end
            ST_ALARM: begin
                if (alarm_ack_i && !push_i) begin
                    state_n = ST_LOCKED;
                end
            end
            default: state_n = ST_LOCKED;
        endcase
    end

    assign locked_o      = (state == ST_LOCKED) || (state == ST_ALARM);
    assign unlocked_o    = (state == ST_UNLOCKED);
    assign alarm_o       = (state == ST_ALARM);
    assign credit_o      = credit;
    assign counter_o     = counter;
    assign coin_reject_o = reject;

endmodule

// File: tb/tb_catraca_tarifada.sv
// Turnstile bench: directed scenarios plus random traffic against a reference model.
module tb_catraca_tarifada;

    localparam int FARE       = 2;
    localparam int MAX_CREDIT = 3;
    localparam int TIMEOUT    = 4;
    localparam int CNT_W      = 3;

    logic       clk = 1'b0;
    logic       rst, coin_i, push_i, alarm_ack_i;
    logic       locked_o, unlocked_o, alarm_o, coin_reject_o;
    logic [1:0] credit_o;
    logic [2:0] counter_o;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit m_open, m_alarm, m_rej;
    int m_credit, m_count, m_left;

    catraca_tarifada #(
        .FARE(FARE), .MAX_CREDIT(MAX_CREDIT),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .coin_i(coin_i), .push_i(push_i),
        .alarm_ack_i(alarm_ack_i), .locked_o(locked_o),
        .unlocked_o(unlocked_o), .alarm_o(alarm_o),
        .credit_o(credit_o), .counter_o(counter_o),
        .coin_reject_o(coin_reject_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit c, input bit p, input bit a);
        int nc;
        if (r) begin
            m_open = 0; m_alarm = 0; m_rej = 0;
            m_credit = 0; m_count = 0; m_left = 0;
            return;
        end
        m_rej = c && (m_credit == MAX_CREDIT);
        nc = (c && m_credit < MAX_CREDIT) ? m_credit + 1 : m_credit;
        m_credit = nc;
        if (m_alarm) begin
            if (a && !p) m_alarm = 0;
        end else if (m_open) begin
            if (p) begin
                m_open = 0;
                m_count = (m_count + 1) % (1 << CNT_W);
            end else begin
                m_left--;
                if (m_left == 0) m_open = 0;
            end
        end else if (p) begin
            m_alarm = 1;
        end else if (nc >= FARE) begin
            m_open = 1;
            m_left = TIMEOUT;
            m_credit = nc - FARE;
        end
    endtask

    task automatic compare_all();
        chk("locked",   int'(locked_o),      int'(m_alarm || !m_open));
        chk("unlocked", int'(unlocked_o),    int'(m_open));
        chk("alarm",    int'(alarm_o),       int'(m_alarm));
        chk("credit",   int'(credit_o),      m_credit);
        chk("counter",  int'(counter_o),     m_count);
        chk("reject",   int'(coin_reject_o), int'(m_rej));
    endtask

    task automatic cyc(input bit r, input bit c, input bit p, input bit a);
        rst = r; coin_i = c; push_i = p; alarm_ack_i = a;
        @(posedge clk);
        model_step(r, c, p, a);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst = 1'b1; coin_i = 0; push_i = 0; alarm_ack_i = 0;
        @(negedge clk);
        cyc(1, 0, 0, 0);
        // reset state against fixed constants
        chk("rst_locked", int'(locked_o), 1);
        chk("rst_credit", int'(credit_o), 0);
        // push while locked -> alarm; ack clears
        cyc(0, 0, 1, 0);
        chk("alarm_set", int'(alarm_o), 1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 1);
        chk("alarm_clr", int'(alarm_o), 0);
        // two coins, pass
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("unlock2", int'(unlocked_o), 1);
        cyc(0, 0, 1, 0);
        chk("count1", int'(counter_o), 1);
        // timeout window
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
        chk("timeout_lock", int'(locked_o), 1);
        // saturation while unlocked, then prepaid re-unlock
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        chk("sat_reject", int'(coin_reject_o), 1);
        cyc(0, 0, 0, 0);
        chk("prepaid", int'(unlocked_o), 1);
        cyc(0, 0, 1, 0);
        // eight paid passages wrap the counter
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 0);
            cyc(0, 1, 0, 0);
            cyc(0, 0, 1, 0);
        end
        chk("wrap", int'(counter_o), 0);
        // push on the final timeout cycle is still a passage
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("push_at_to", int'(counter_o), 1);
        // reset mid-unlock with credit
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 1, 0);
        chk("rst_mid", int'(credit_o), 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 59) == 0),
                ($urandom_range(0, 9) < 4),
                ($urandom_range(0, 9) < 2),
                ($urandom_range(0, 9) < 3));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
